// File: rtl/bcd_timer_controller_if.sv
// bcd_timer_controller_if: button-side controls and display-side digits/enables of the BCD timer
interface bcd_timer_controller_if;
    logic        tick;
    logic        start_stop;
    logic        clear;
    logic        mode;
    logic        set_en;
    logic [15:0] set_value;
    logic [3:0]  value0;
    logic [3:0]  value1;
    logic [3:0]  value2;
    logic [3:0]  value3;
    logic        increase_en;
    logic        decrease_en;
    logic        running;
    logic        done;
    modport master (
        output tick, start_stop, clear, mode, set_en, set_value,
        input  value0, value1, value2, value3, increase_en, decrease_en, running, done
    );
    modport slave (
        input  tick, start_stop, clear, mode, set_en, set_value,
        output value0, value1, value2, value3, increase_en, decrease_en, running, done
    );
endinterface

// File: rtl/bcd_timer_controller.sv
// bcd_timer_controller: run/pause/done FSM owning the four BCD digits of the up/down timer
module bcd_timer_controller #(
    parameter logic [15:0] UP_LIMIT = 16'h9999
) (
    input logic clk,
    input logic rst,
    bcd_timer_controller_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
    logic [1:0]  state;
    logic        dir;
    logic [15:0] d;
    logic [15:0] up;
    logic [15:0] dn;
    logic        c;
    logic        b;
    logic [15:0] nx;
    logic        at_end;
    logic        set_ok;
    always_comb begin
        c  = 1'b1;
        b  = 1'b1;
        up = d;
        dn = d;
        for (int k = 0; k < 4; k++) begin
            up[k*4+:4] = c ? (d[k*4+:4] == 4'd9 ? 4'd0 : d[k*4+:4] + 4'd1) : d[k*4+:4];
            dn[k*4+:4] = b ? (d[k*4+:4] == 4'd0 ? 4'd9 : d[k*4+:4] - 4'd1) : d[k*4+:4];
            c = c & (d[k*4+:4] == 4'd9);
            b = b & (d[k*4+:4] == 4'd0);
        end
    end
    assign nx     = dir ? dn : up;
    // guards against stepping past a terminal value preset while paused
    assign at_end = dir ? (d == 16'h0000) : (d >= UP_LIMIT);
    assign set_ok = (bus.set_value[3:0] <= 4'd9) && (bus.set_value[7:4] <= 4'd9) &&
                    (bus.set_value[11:8] <= 4'd9) && (bus.set_value[15:12] <= 4'd9);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir   <= 1'b0;
            d     <= 16'h0000;
        end else if (bus.clear) begin
            state <= IDLE;
            d     <= 16'h0000;
        end else if (bus.set_en) begin
            if (state != RUN && set_ok) begin
                d     <= bus.set_value;
                state <= (state == DONE) ? IDLE : state;
            end
        end else if (bus.start_stop) begin
            if (state == IDLE) begin
                if (!(bus.mode ? d == 16'h0000 : d == UP_LIMIT)) begin
                    dir   <= bus.mode;
                    state <= RUN;
                end
            end else if (state == RUN) begin
                state <= PAUSE;
            end else if (state == PAUSE) begin
                state <= RUN;
            end
        end else if (bus.tick && state == RUN) begin
            if (at_end) begin
                state <= DONE;
            end else begin
                d     <= nx;
                state <= (nx == (dir ? 16'h0000 : UP_LIMIT)) ? DONE : RUN;
            end
        end
    end
    assign bus.value0      = d[3:0];
    assign bus.value1      = d[7:4];
    assign bus.value2      = d[11:8];
    assign bus.value3      = d[15:12];
    assign bus.running     = state == RUN;
    assign bus.done        = state == DONE;
    assign bus.increase_en = (state == RUN) & ~dir;
    assign bus.decrease_en = (state == RUN) & dir;
endmodule

// File: tb/tb_bcd_timer_controller.sv
// tb_bcd_timer_controller: directed scenarios with hand-computed digit and flag expectations
module tb_bcd_timer_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    bcd_timer_controller_if bus ();
    bcd_timer_controller dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [15:0] dig;
    logic [3:0]  flags;
    assign dig   = {bus.value3, bus.value2, bus.value1, bus.value0};
    assign flags = {bus.increase_en, bus.decrease_en, bus.running, bus.done};
    task automatic step(input logic t, input logic ss, input logic cl, input logic se, input logic [15:0] sv);
        bus.tick = t;
        bus.start_stop = ss;
        bus.clear = cl;
        bus.set_en = se;
        bus.set_value = sv;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear = 1'b0;
        bus.set_en = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (dig !== 16'h0000) begin $display("FAIL reset_digits got=%h exp=0000", dig); bad++; end
        total++;
        if (flags !== 4'b0000) begin $display("FAIL reset_flags got=%b exp=0000", flags); bad++; end
    endtask
    task automatic test_refused_start;
        bus.mode = 1'b1;
        step(0, 1, 0, 0, 16'h0);
        total++;
        if (flags !== 4'b0000) begin $display("FAIL refused_start_flags got=%b exp=0000", flags); bad++; end
        total++;
        if (dig !== 16'h0000) begin $display("FAIL refused_start_digits got=%h exp=0000", dig); bad++; end
    endtask
    task automatic test_count_down;
        logic [15:0] exp_d [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                                   16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
        step(0, 0, 0, 1, 16'h0012);
        total++;
        if (dig !== 16'h0012) begin $display("FAIL down_preset got=%h exp=0012", dig); bad++; end
        bus.mode = 1'b1;
        step(0, 1, 0, 0, 16'h0);
        total++;
        if (flags !== 4'b0110) begin $display("FAIL down_start_flags got=%b exp=0110", flags); bad++; end
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0, 16'h0);
            total++;
            if (dig !== exp_d[i]) begin $display("FAIL down_tick%0d got=%h exp=%h", i, dig, exp_d[i]); bad++; end
            total++;
            if (flags !== (i == 11 ? 4'b0001 : 4'b0110)) begin
                $display("FAIL down_flags%0d got=%b exp=%b", i, flags, (i == 11 ? 4'b0001 : 4'b0110)); bad++;
            end
        end
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        total++;
        if (dig !== 16'h0000) begin $display("FAIL done_hold_digits got=%h exp=0000", dig); bad++; end
        total++;
        if (flags !== 4'b0001) begin $display("FAIL done_hold_flags got=%b exp=0001", flags); bad++; end
    endtask
    task automatic test_carry;
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0099);
        bus.mode = 1'b0;
        step(0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        total++;
        if (dig !== 16'h0100) begin $display("FAIL carry_chain got=%h exp=0100", dig); bad++; end
        total++;
        if (flags !== 4'b1010) begin $display("FAIL carry_flags got=%b exp=1010", flags); bad++; end
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h9998);
        step(0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        total++;
        if (dig !== 16'h9999) begin $display("FAIL up_limit_digits got=%h exp=9999", dig); bad++; end
        total++;
        if (flags !== 4'b0001) begin $display("FAIL up_limit_flags got=%b exp=0001", flags); bad++; end
    endtask
    task automatic test_pause;
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0050);
        bus.mode = 1'b0;
        step(0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        total++;
        if (dig !== 16'h0051) begin $display("FAIL pause_pre_tick got=%h exp=0051", dig); bad++; end
        step(1, 1, 0, 0, 16'h0);
        total++;
        if (dig !== 16'h0051) begin $display("FAIL pause_no_step got=%h exp=0051", dig); bad++; end
        total++;
        if (flags !== 4'b0000) begin $display("FAIL pause_flags got=%b exp=0000", flags); bad++; end
        bus.mode = 1'b1;
        step(1, 0, 0, 0, 16'h0);
        total++;
        if (dig !== 16'h0051) begin $display("FAIL pause_tick_ignored got=%h exp=0051", dig); bad++; end
        step(0, 1, 0, 0, 16'h0);
        total++;
        if (flags !== 4'b1010) begin $display("FAIL resume_dir got=%b exp=1010", flags); bad++; end
        step(1, 0, 0, 0, 16'h0);
        total++;
        if (dig !== 16'h0052) begin $display("FAIL resume_up_step got=%h exp=0052", dig); bad++; end
    endtask
    task automatic test_set_ignored;
        step(0, 0, 0, 1, 16'h1234);
        total++;
        if (dig !== 16'h0052) begin $display("FAIL set_in_run got=%h exp=0052", dig); bad++; end
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h00A5);
        total++;
        if (dig !== 16'h0000) begin $display("FAIL set_invalid got=%h exp=0000", dig); bad++; end
        step(0, 0, 0, 1, 16'h0005);
        total++;
        if (dig !== 16'h0005) begin $display("FAIL set_valid got=%h exp=0005", dig); bad++; end
    endtask
    task automatic test_clear_set;
        bus.mode = 1'b0;
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        step(0, 0, 1, 1, 16'h0333);
        total++;
        if (dig !== 16'h0000) begin $display("FAIL clear_over_set_digits got=%h exp=0000", dig); bad++; end
        total++;
        if (flags !== 4'b0000) begin $display("FAIL clear_over_set_flags got=%b exp=0000", flags); bad++; end
        step(0, 0, 0, 1, 16'h9998);
        step(0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0007);
        total++;
        if (dig !== 16'h0007) begin $display("FAIL set_from_done_digits got=%h exp=0007", dig); bad++; end
        total++;
        if (flags !== 4'b0000) begin $display("FAIL set_from_done_flags got=%b exp=0000", flags); bad++; end
    endtask
    task automatic test_reset_mid_run;
        step(0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        total++;
        if (dig !== 16'h0008) begin $display("FAIL run_before_rst got=%h exp=0008", dig); bad++; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (dig !== 16'h0000) begin $display("FAIL rst_mid_run_digits got=%h exp=0000", dig); bad++; end
        total++;
        if (flags !== 4'b0000) begin $display("FAIL rst_mid_run_flags got=%b exp=0000", flags); bad++; end
    endtask
    initial begin
        bus.tick = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear = 1'b0;
        bus.mode = 1'b0;
        bus.set_en = 1'b0;
        bus.set_value = 16'h0;
        test_reset;
        test_refused_start;
        test_count_down;
        test_carry;
        test_pause;
        test_set_ignored;
        test_clear_set;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
